// File: rtl/wb_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mem_pkg
//  Purpose  : Shared Wishbone cycle-type / burst-type constants and the
//             responder FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_mem_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

`ifdef WB_MEM_WAIT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        ACK   = 3'd2,
        BURST = 3'd3,
        ERR   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK   = 3'd2,
        BURST = 3'd3,
        ERR   = 3'd4
    } state_t;
`endif

    // Reserved and unsupported cycle types behave as classic transfers.
    function automatic logic [2:0] normalize_cti(input logic [2:0] cti);
        if (cti == CTI_INCR || cti == CTI_END)
            return cti;
        return CTI_CLASSIC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mem_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mem_addr_gen
//  Purpose  : Next beat byte address for Wishbone incrementing bursts,
//             linear or wrapping on 4/8/16-word boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_mem_addr_gen
    import wb_mem_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  bte,
    output logic [31:0] next_addr
);

    // Beats are word aligned; the byte offset never takes part.
    logic unused_low;
    assign unused_low = ^addr[1:0];

    // Advance one word; wrapping modes increment only the in-block word bits
    // and keep everything above the wrap boundary.
    always_comb begin
        next_addr = {addr[31:2] + 30'd1, 2'b00};
        case (bte)
            BTE_LINEAR: next_addr = {addr[31:2] + 30'd1, 2'b00};
            BTE_WRAP4:  next_addr = {addr[31:4], addr[3:2] + 2'd1, 2'b00};
            BTE_WRAP8:  next_addr = {addr[31:5], addr[4:2] + 3'd1, 2'b00};
            BTE_WRAP16: next_addr = {addr[31:6], addr[5:2] + 4'd1, 2'b00};
            default:    next_addr = {addr[31:2] + 30'd1, 2'b00};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mem_responder
//  Purpose  : Wishbone slave memory with classic and incrementing-burst
//             support, byte-lane writes and error response outside the
//             mapped window.
//  Options  : WB_MEM_WAIT_EN - insert WAIT_CYCLES wait states before the
//             first beat of every transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_mem_responder
    import wb_mem_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam int          WORDS     = 1 << DEPTH_LOG2;
    localparam logic [32:0] MEM_BYTES = 33'(WORDS) << 2;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [WORDS];

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  bte_q, bte_d;
    logic [31:0] dat_q;
    logic [31:0] next_addr;
    logic [31:0] rd_addr;
    logic        rd_load;
    logic        wr_en;
    logic        go;
    logic        beat_acked;

`ifdef WB_MEM_WAIT_EN
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
    logic [7:0] wait_q, wait_d;
`else
    logic unused_cfg;
    assign unused_cfg = (WAIT_CYCLES != 0);
`endif

    wb_mem_addr_gen u_addr_gen (
        .addr      (addr_q),
        .bte       (bte_q),
        .next_addr (next_addr)
    );

    assign beat_acked = ack_q & wb_cyc_i & wb_stb_i;
    assign wb_ack_o   = ack_q & wb_cyc_i & wb_stb_i;
    assign wb_err_o   = err_q & wb_cyc_i & wb_stb_i;
    assign wb_rty_o   = 1'b0;
    assign wb_dat_o   = dat_q;

    // State, handshake flags and burst address; reset abandons any transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            bte_q   <= BTE_LINEAR;
`ifdef WB_MEM_WAIT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            bte_q   <= bte_d;
`ifdef WB_MEM_WAIT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Next state, beat sequencing and memory read/write requests
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        err_d   = err_q;
        addr_d  = addr_q;
        bte_d   = bte_q;
        rd_load = 1'b0;
        rd_addr = addr_q;
        wr_en   = 1'b0;
        go      = 1'b0;
`ifdef WB_MEM_WAIT_EN
        wait_d  = wait_q;
`endif
        if (!wb_cyc_i) begin
            // Master gave up the bus: drop everything without a final response
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
`ifdef WB_MEM_WAIT_EN
            wait_d  = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (wb_stb_i) begin
`ifdef WB_MEM_WAIT_EN
                        if (WAIT_CYCLES == 0) begin
                            go = 1'b1;
                        end else begin
                            state_d = WAIT;
                            wait_d  = '0;
                        end
`else
                        go = 1'b1;
`endif
                    end
                end
`ifdef WB_MEM_WAIT_EN
                WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        go     = 1'b1;
                        wait_d = '0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
`endif
                ACK: begin
                    wr_en   = beat_acked & wb_we_i;
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
                ERR: begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
                BURST: begin
                    // A stalled beat (stb low) holds address, data and ack_q
                    if (beat_acked) begin
                        wr_en = wb_we_i;
                        if (wb_cti_i == CTI_END) begin
                            state_d = IDLE;
                            ack_d   = 1'b0;
                        end else if (!in_range(next_addr)) begin
                            state_d = ERR;
                            ack_d   = 1'b0;
                            err_d   = 1'b1;
                        end else begin
                            addr_d  = next_addr;
                            rd_load = 1'b1;
                            rd_addr = next_addr;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            endcase

            // First beat of a transfer: classify and prefetch its read data
            if (go) begin
                addr_d = wb_adr_i;
                bte_d  = wb_bte_i;
                if (!in_range(wb_adr_i)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    ack_d   = 1'b0;
                end else begin
                    rd_load = 1'b1;
                    rd_addr = wb_adr_i;
                    ack_d   = 1'b1;
                    state_d = (normalize_cti(wb_cti_i) == CTI_INCR) ? BURST : ACK;
                end
            end
        end
    end

    // Byte-lane writes on acknowledged write beats; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b])
                    mem[word_index(addr_q)][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    // Read data register, loaded one cycle ahead of the beat it serves
    always_ff @(posedge clk) begin
        if (!rst_n)
            dat_q <= '0;
        else if (rd_load)
            dat_q <= mem[word_index(rd_addr)];
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_wb_mem_responder
//  Purpose  : Self-checking bench for wb_mem_responder against a word-array
//             reference model of the memory and burst address sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_mem_responder;

    localparam int DEPTH_LOG2  = 12;
    localparam int WORDS       = 1 << DEPTH_LOG2;
    localparam int WAIT_CYCLES = 2;
`ifdef WB_MEM_WAIT_EN
    localparam int FIRST_LAT   = 1 + WAIT_CYCLES;
`else
    localparam int FIRST_LAT   = 1;
`endif
    localparam int MAX_CYC     = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic [31:0] wb_dat_i = '0;
    logic [2:0]  wb_cti_i = 3'b000;
    logic [1:0]  wb_bte_i = 2'b00;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    always #5 clk = ~clk;

    wb_mem_responder #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_i (wb_dat_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o)
    );

    int checks = 0;
    int fails  = 0;

    logic [31:0] model_mem [WORDS];
    logic [2:0]  classic_ctis [6] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110};

    logic [31:0] wdata [$];
    logic [31:0] obs_data [$];
    int          obs_cyc [$];
    int          obs_err;
    int          obs_err_cyc;
    int          spurious;
    bit          timed_out;

    // Word visited after word w in a burst: wrap modes stay inside an
    // aligned block of 4/8/16 words.
    function automatic int next_word(input int w, input logic [1:0] bte);
        int span;
        case (bte)
            2'b01:   span = 4;
            2'b10:   span = 8;
            2'b11:   span = 16;
            default: span = 0;
        endcase
        if (span == 0)
            return w + 1;
        return (w / span) * span + ((w % span) + 1) % span;
    endfunction

    function automatic void model_write(input int w, input logic [3:0] sel, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (sel[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
    endfunction

    // Bus master: runs one transfer, recording acked data and cycle numbers
    // (cycle 0 = first cycle with stb high). Write data comes from wdata.
    task automatic do_xfer(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                           input bit burst, input logic [1:0] bte, input int nbeats,
                           input int stall_after, input int stall_len, input logic [2:0] ccti);
        int beat, cyc_n, stall_left;
        bit hit;
        obs_data.delete();
        obs_cyc.delete();
        obs_err = 0; obs_err_cyc = -1; spurious = 0; timed_out = 0;
        beat = 0; cyc_n = 0; stall_left = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
        wb_sel_i = sel; wb_bte_i = bte;
        wb_dat_i = (wdata.size() > 0) ? wdata[0] : 32'h0;
        wb_cti_i = !burst ? ccti : ((nbeats == 1) ? 3'b111 : 3'b010);
        while (beat < nbeats && obs_err == 0 && !timed_out) begin
            @(negedge clk);
            hit = 1'b0;
            if (wb_rty_o) spurious++;
            if (wb_stb_i && wb_ack_o) begin
                obs_data.push_back(wb_dat_o);
                obs_cyc.push_back(cyc_n);
                beat++;
                hit = 1'b1;
            end else if (wb_stb_i && wb_err_o) begin
                obs_err++;
                obs_err_cyc = cyc_n;
            end else if (!wb_stb_i && (wb_ack_o || wb_err_o)) begin
                spurious++;
            end
            @(posedge clk); #1;
            cyc_n++;
            if (cyc_n >= MAX_CYC) timed_out = 1'b1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) wb_stb_i = 1'b1;
            end else if (hit && beat == stall_after && stall_len > 0 && beat < nbeats) begin
                wb_stb_i   = 1'b0;
                stall_left = stall_len;
            end
            if (hit) begin
                if (beat < wdata.size()) wb_dat_i = wdata[beat];
                if (burst && beat == nbeats - 1) wb_cti_i = 3'b111;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
        @(negedge clk);
        if (wb_ack_o || wb_err_o || wb_rty_o) spurious++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (wb_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", wb_ack_o); end
        checks++; if (wb_err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", wb_err_o); end
        checks++; if (wb_rty_o !== 1'b0) begin fails++; $display("FAIL reset_rty: got %b want 0", wb_rty_o); end
        checks++; if (wb_dat_o !== 32'h0) begin fails++; $display("FAIL reset_dat: got %h want 00000000", wb_dat_o); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        wdata.delete();
        for (int i = 0; i < 64; i++) wdata.push_back(32'h1000_0000 + i);
        do_xfer(32'h0, 1'b1, 4'hF, 1'b1, 2'b00, 64, 0, 0, 3'b000);
        checks++;
        if (obs_data.size() != 64 || obs_err != 0 || spurious != 0 || timed_out) begin
            fails++; $display("FAIL fill_burst: acks %0d err %0d spurious %0d want 64/0/0", obs_data.size(), obs_err, spurious);
        end
        checks++;
        if (obs_cyc.size() < 64 || obs_cyc[0] != FIRST_LAT || obs_cyc[63] != FIRST_LAT + 63) begin
            fails++; $display("FAIL fill_timing: first %0d want %0d", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, FIRST_LAT);
        end
        for (int i = 0; i < obs_data.size(); i++) model_write(i, 4'hF, wdata[i]);
        for (int k = 0; k < 2; k++) begin
            wdata.delete();
            wdata.push_back((k == 0) ? 32'hCAFE_0FFE : 32'h5EED_1234);
            do_xfer(32'h3FF8 + 4 * k, 1'b1, 4'hF, 1'b0, 2'b00, 1, 0, 0, 3'b000);
            checks++;
            if (obs_data.size() != 1 || obs_err != 0 || spurious != 0) begin
                fails++; $display("FAIL top_write: acks %0d err %0d want 1/0", obs_data.size(), obs_err);
            end
            if (obs_data.size() == 1) model_write(WORDS - 2 + k, 4'hF, wdata[0]);
        end
        wdata.delete();
    endtask

    task automatic test_wrap8_read();
        int w;
        wdata.delete();
        do_xfer(32'h14, 1'b0, 4'hF, 1'b1, 2'b10, 8, 0, 0, 3'b000);
        checks++;
        if (obs_data.size() != 8 || obs_err != 0 || spurious != 0 || timed_out) begin
            fails++; $display("FAIL wrap8_count: acks %0d want 8", obs_data.size());
        end
        w = 5;
        for (int i = 0; i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== model_mem[w] || obs_cyc[i] != FIRST_LAT + i) begin
                fails++; $display("FAIL wrap8_beat%0d: got %h @%0d want %h @%0d", i, obs_data[i], obs_cyc[i], model_mem[w], FIRST_LAT + i);
            end
            w = next_word(w, 2'b10);
        end
        checks++;
        if (obs_data.size() == 8 && (obs_data[3] !== 32'h1000_0000 || obs_data[7] !== 32'h1000_0004)) begin
            fails++; $display("FAIL wrap8_edge: got %h,%h want 10000000,10000004", obs_data[3], obs_data[7]);
        end
    endtask

    task automatic test_masked_write();
        wdata.delete(); wdata.push_back(32'h1122_3344);
        do_xfer(32'h40, 1'b1, 4'hF, 1'b0, 2'b00, 1, 0, 0, 3'b000);
        if (obs_data.size() == 1) model_write(16, 4'hF, 32'h1122_3344);
        wdata.delete(); wdata.push_back(32'hAABB_CCDD);
        do_xfer(32'h40, 1'b1, 4'b0101, 1'b0, 2'b00, 1, 0, 0, 3'b000);
        if (obs_data.size() == 1) model_write(16, 4'b0101, 32'hAABB_CCDD);
        wdata.delete(); wdata.push_back(32'hFFFF_FFFF);
        do_xfer(32'h40, 1'b1, 4'b0000, 1'b0, 2'b00, 1, 0, 0, 3'b000);
        checks++;
        if (obs_data.size() != 1 || obs_err != 0) begin
            fails++; $display("FAIL sel0_ack: acks %0d err %0d want 1/0", obs_data.size(), obs_err);
        end
        wdata.delete();
        do_xfer(32'h40, 1'b0, 4'hF, 1'b0, 2'b00, 1, 0, 0, 3'b000);
        checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'h11BB_33DD || obs_cyc[0] != FIRST_LAT) begin
            fails++; $display("FAIL masked_read: got %h @%0d want 11bb33dd @%0d",
                              (obs_data.size() > 0) ? obs_data[0] : 32'hx, (obs_cyc.size() > 0) ? obs_cyc[0] : -1, FIRST_LAT);
        end
    endtask

    task automatic test_out_of_range();
        wdata.delete(); wdata.push_back(32'hDEAD_BEEF);
        do_xfer(32'h4000, 1'b1, 4'hF, 1'b0, 2'b00, 1, 0, 0, 3'b000);
        checks++;
        if (obs_err != 1 || obs_data.size() != 0 || obs_err_cyc != FIRST_LAT || spurious != 0) begin
            fails++; $display("FAIL oor_write: err %0d @%0d acks %0d want 1 @%0d, 0 acks", obs_err, obs_err_cyc, obs_data.size(), FIRST_LAT);
        end
        wdata.delete();
        do_xfer(32'h0, 1'b0, 4'hF, 1'b0, 2'b00, 1, 0, 0, 3'b000);
        checks++;
        if (obs_data.size() != 1 || obs_data[0] !== model_mem[0]) begin
            fails++; $display("FAIL oor_nowrite: got %h want %h", (obs_data.size() > 0) ? obs_data[0] : 32'hx, model_mem[0]);
        end
        do_xfer(32'h3FF8, 1'b0, 4'hF, 1'b1, 2'b00, 4, 0, 0, 3'b000);
        checks++;
        if (obs_data.size() != 2 || obs_err != 1 || spurious != 0) begin
            fails++; $display("FAIL oor_burst: acks %0d err %0d want 2/1", obs_data.size(), obs_err);
        end
        checks++;
        if (obs_data.size() == 2 && (obs_data[0] !== model_mem[WORDS-2] || obs_data[1] !== model_mem[WORDS-1])) begin
            fails++; $display("FAIL oor_burst_data: got %h,%h want %h,%h", obs_data[0], obs_data[1], model_mem[WORDS-2], model_mem[WORDS-1]);
        end
    endtask

    task automatic test_stall();
        wdata.delete();
        do_xfer(32'h0, 1'b0, 4'hF, 1'b1, 2'b00, 6, 3, 2, 3'b000);
        checks++;
        if (obs_data.size() != 6 || spurious != 0 || obs_err != 0) begin
            fails++; $display("FAIL stall_count: acks %0d spurious %0d want 6/0", obs_data.size(), spurious);
        end
        for (int i = 0; i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== model_mem[i]) begin
                fails++; $display("FAIL stall_beat%0d: got %h want %h", i, obs_data[i], model_mem[i]);
            end
        end
        checks++;
        if (obs_cyc.size() == 6 && obs_cyc[3] != obs_cyc[2] + 3) begin
            fails++; $display("FAIL stall_gap: beat4 @%0d want @%0d", obs_cyc[3], obs_cyc[2] + 3);
        end
    endtask

    task automatic test_reset_mid_burst();
        int acks, cyc_n;
        bit done;
        acks = 0; cyc_n = 0; done = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
        wb_sel_i = 4'hF; wb_cti_i = 3'b010; wb_bte_i = 2'b00;
        while (!done && cyc_n < MAX_CYC) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
            if (acks == 3) begin
                rst_n = 1'b0;
                done  = 1'b1;
            end
            @(posedge clk); #1;
            cyc_n++;
        end
        checks++;
        if (!done) begin fails++; $display("FAIL rstmid_timeout: acks %0d want 3", acks); end
        @(negedge clk);
        checks++; if (wb_ack_o !== 1'b0) begin fails++; $display("FAIL rstmid_ack: got %b want 0", wb_ack_o); end
        checks++; if (wb_dat_o !== 32'h0) begin fails++; $display("FAIL rstmid_dat: got %h want 00000000", wb_dat_o); end
        rst_n = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000;
        @(posedge clk); #1;
        wdata.delete();
        do_xfer(32'h8, 1'b0, 4'hF, 1'b0, 2'b00, 1, 0, 0, 3'b000);
        checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'h1000_0002) begin
            fails++; $display("FAIL rstmid_read: got %h want 10000002", (obs_data.size() > 0) ? obs_data[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            bit          burst, we;
            logic [1:0]  bte;
            logic [3:0]  sel;
            logic [2:0]  ccti;
            int          n, w0, w, sa, sl;
            int          words [$];
            burst = bit'($urandom_range(0, 1));
            we    = bit'($urandom_range(0, 1));
            bte   = burst ? 2'($urandom_range(0, 3)) : 2'b00;
            n     = burst ? $urandom_range(2, 10) : 1;
            w0    = (bte == 2'b00) ? $urandom_range(0, 64 - n) : $urandom_range(0, 63);
            sel   = we ? 4'($urandom_range(0, 15)) : 4'hF;
            ccti  = classic_ctis[$urandom_range(0, 5)];
            sa = 0; sl = 0;
            if (burst && $urandom_range(0, 1) == 1) begin
                sa = $urandom_range(1, n - 1);
                sl = $urandom_range(1, 3);
            end
            wdata.delete();
            words.delete();
            w = w0;
            for (int i = 0; i < n; i++) begin
                wdata.push_back($urandom);
                words.push_back(w);
                w = next_word(w, bte);
            end
            do_xfer(32'(w0 * 4), we, sel, burst, bte, n, sa, sl, ccti);
            checks++;
            if (obs_data.size() != n || obs_err != 0 || spurious != 0 || timed_out || obs_cyc[0] != FIRST_LAT) begin
                fails++; $display("FAIL rand%0d_xfer: acks %0d err %0d spurious %0d want %0d/0/0", it, obs_data.size(), obs_err, spurious, n);
            end
            for (int i = 0; i < obs_data.size(); i++) begin
                if (we) begin
                    model_write(words[i], sel, wdata[i]);
                end else begin
                    checks++;
                    if (obs_data[i] !== model_mem[words[i]]) begin
                        fails++; $display("FAIL rand%0d_beat%0d: word %0d got %h want %h", it, i, words[i], obs_data[i], model_mem[words[i]]);
                    end
                end
            end
        end
        wdata.delete();
        do_xfer(32'h0, 1'b0, 4'hF, 1'b1, 2'b00, 64, 0, 0, 3'b000);
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== model_mem[i]) begin
                fails++; $display("FAIL final_word%0d: got %h want %h", i, (i < obs_data.size()) ? obs_data[i] : 32'hx, model_mem[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_wrap8_read();
        test_masked_write();
        test_out_of_range();
        test_stall();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
